ifetch_prefetch: RTL and testbench

//   Instruction prefetch stage between the instruction memory and the cpu decode path.

---
 rtl/ifetch_prefetch.sv | 172 +++++++++++++++++
 tb/tb_ifetch_prefetch.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_prefetch.sv
// ============================================================================
// Module  : ifetch_prefetch
// Brief   : Instruction prefetch stage. It fetches sequential words over a
//           single-outstanding req/ack handshake, buffers {pc,instr} in a
//           DEPTH-entry FIFO, and flushes and restarts on a redirect.
//           Optional macro IFETCH_BYPASS_EN: when the FIFO is empty, an ack
//           word goes straight to decode in the cycle it arrives.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module ifetch_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic [31:0] o_inst_data,
  output logic [31:0] o_inst_pc
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] c_FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   w_fetch_pc_nxt;
  logic [31:0]   r_tgt_q;
  logic [31:0]   w_tgt_nxt;
  logic [31:0]   r_pc_mem   [DEPTH];
  logic [31:0]   r_data_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic        w_empty;
  logic        w_full;
  logic        w_req;
  logic        w_valid;
  logic        w_push;
  logic        w_pop;
  logic        w_flush;
  logic        w_bypass;
  logic [31:0] w_redir_pc;
  logic        w_unused;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == c_FULL_CNT);
  assign w_redir_pc = {i_redirect_pc[31:2], 2'b00};
  assign w_unused   = ^i_redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_fetch_pc <= RESET_PC;
      r_tgt_q    <= 32'h0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_tgt_q    <= w_tgt_nxt;
    end
  end

  // rst_n gates the request so it drops the instant reset asserts mid-request
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_tgt_nxt      = r_tgt_q;
    w_req          = 1'b0;
    w_valid        = 1'b0;
    w_push         = 1'b0;
    w_flush        = 1'b0;
    w_bypass       = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_req = rst_n && !w_full;
        if (i_redirect_valid) begin
          w_flush = 1'b1;
          if (!w_req || i_mem_ack) begin
            w_fetch_pc_nxt = w_redir_pc;
          end else begin
            w_tgt_nxt   = w_redir_pc;
            w_state_nxt = ST_DRAIN;
          end
        end else begin
          w_valid = rst_n && !w_empty;
          if (w_req && i_mem_ack) begin
            w_push         = 1'b1;
            w_fetch_pc_nxt = r_fetch_pc + 32'd4;
`ifdef IFETCH_BYPASS_EN
            if (w_empty) begin
              w_bypass = 1'b1;
              w_valid  = 1'b1;
              w_push   = !i_inst_ready;
            end
`endif
          end
        end
      end
      ST_DRAIN: begin
        w_req = rst_n;
        if (i_redirect_valid) begin
          w_tgt_nxt = w_redir_pc;
        end
        // stale word is discarded; the most recent target wins
        if (i_mem_ack) begin
          w_fetch_pc_nxt = i_redirect_valid ? w_redir_pc : r_tgt_q;
          w_state_nxt    = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  assign w_pop = w_valid && i_inst_ready && !w_bypass;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= r_fetch_pc;
      r_data_mem[r_wr_ptr] <= i_mem_rdata;
    end
  end

  assign o_mem_req    = w_req;
  assign o_mem_addr   = r_fetch_pc;
  assign o_inst_valid = w_valid;
  assign o_inst_data  = w_bypass ? i_mem_rdata :
                        (w_empty ? 32'h0 : r_data_mem[r_rd_ptr]);
  assign o_inst_pc    = w_bypass ? r_fetch_pc :
                        (w_empty ? 32'h0 : r_pc_mem[r_rd_ptr]);

endmodule

`default_nettype wire

// File: tb/tb_ifetch_prefetch.sv
// ============================================================================
// Module  : tb_ifetch_prefetch
// Brief   : Self-checking bench for ifetch_prefetch against a queue-based
//           reference model, using directed and random stimulus.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ifetch_prefetch;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  logic        hi_req;
  logic [31:0] hi_addr;
  logic        hi_unused_valid;
  logic [31:0] hi_unused_data;
  logic [31:0] hi_unused_pc;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_tgt;
  bit          m_drain;

  always #5 clk = ~clk;

  ifetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_redirect_valid(redirect_valid), .i_redirect_pc(redirect_pc),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
    .o_inst_valid(inst_valid), .i_inst_ready(inst_ready),
    .o_inst_data(inst_data), .o_inst_pc(inst_pc)
  );

  // High reset address, always acked and always drained, to exercise the wrap
  ifetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_dut_hi (
    .clk(clk), .rst_n(rst_n),
    .i_redirect_valid(1'b0), .i_redirect_pc(32'h0),
    .o_mem_req(hi_req), .o_mem_addr(hi_addr),
    .i_mem_ack(1'b1), .i_mem_rdata(32'hC0DE_0000),
    .o_inst_valid(hi_unused_valid), .i_inst_ready(1'b1),
    .o_inst_data(hi_unused_data), .o_inst_pc(hi_unused_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc    = 32'h0;
    m_tgt   = 32'h0;
    m_drain = 1'b0;
  endtask

  // One cycle: drive inputs, check outputs against the model, advance the model
  task automatic step(input logic redir, input logic [31:0] rpc,
                      input logic ack, input logic rdy);
    logic [31:0] rdata, al, e_data, e_pc;
    logic        e_req, e_valid, acc, byp;
    rdata          = $urandom;
    al             = {rpc[31:2], 2'b00};
    redirect_valid = redir;
    redirect_pc    = rpc;
    mem_ack        = ack;
    mem_rdata      = rdata;
    inst_ready     = rdy;
    #2;
    e_req = m_drain || (mq.size() < DEPTH);
    acc   = ack && e_req;
    byp   = 1'b0;
`ifdef IFETCH_BYPASS_EN
    byp = !m_drain && !redir && (mq.size() == 0) && acc;
`endif
    e_valid = (!m_drain && !redir && (mq.size() > 0)) || byp;
    if (byp) begin
      e_data = rdata;
      e_pc   = m_pc;
    end else if (mq.size() > 0) begin
      e_pc   = mq[0][63:32];
      e_data = mq[0][31:0];
    end else begin
      e_pc   = 32'h0;
      e_data = 32'h0;
    end
    chk("mem_req",    {31'b0, mem_req},    {31'b0, e_req});
    chk("mem_addr",   mem_addr,            m_pc);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, e_valid});
    chk("inst_pc",    inst_pc,             e_pc);
    chk("inst_data",  inst_data,           e_data);
    if (m_drain) begin
      if (redir) m_tgt = al;
      if (acc) begin
        m_pc    = redir ? al : m_tgt;
        m_drain = 1'b0;
      end
    end else if (redir) begin
      mq.delete();
      if (acc || !e_req) begin
        m_pc = al;
      end else begin
        m_tgt   = al;
        m_drain = 1'b1;
      end
    end else begin
      if (e_valid && rdy && !byp) void'(mq.pop_front());
      if (acc && !(byp && rdy)) mq.push_back({m_pc, rdata});
      if (acc) m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    mem_ack        = 1'b0;
    mem_rdata      = 32'h0;
    inst_ready     = 1'b0;
    rst_n          = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req",    {31'b0, mem_req},    32'h0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_inst_data",  inst_data,           32'h0);
    chk("rst_inst_pc",    inst_pc,             32'h0);
    chk("rst_mem_addr",   mem_addr,            32'h0);
    chk("rst_hi_addr",    hi_addr,             32'hFFFF_FFF8);
    chk("rst_hi_req",     {31'b0, hi_req},     32'h0);
    rst_n = 1'b1;

    // Sequential fetch with ack tied high; the high instance wraps past 2^32
    chk("wrap_addr0", hi_addr, 32'hFFFF_FFF8);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("wrap_addr1", hi_addr, 32'hFFFF_FFFC);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("wrap_addr2", hi_addr, 32'h0000_0000);
    repeat (4) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Fill the FIFO with decode stalled, then drain it in order
    step(1'b1, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (5) step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("full_req_low", {31'b0, mem_req}, 32'h0);
    chk("full_addr",    mem_addr,         32'h10);
    repeat (4) step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("resume_addr",  mem_addr,         32'h10);
    step(1'b0, 32'h0, 1'b1, 1'b1);

    // Redirect while a slow request is outstanding
    step(1'b0, 32'h0,   1'b0, 1'b1);
    step(1'b1, 32'h100, 1'b0, 1'b1);
    step(1'b0, 32'h0,   1'b0, 1'b1);
    step(1'b0, 32'h0,   1'b1, 1'b1);
    chk("drain_target", mem_addr, 32'h100);
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b1);

    // Redirect to an unaligned target in the same cycle as an ack
    step(1'b1, 32'h38, 1'b1, 1'b0);
    step(1'b0, 32'h0,  1'b1, 1'b0);
    step(1'b0, 32'h0,  1'b1, 1'b0);
    chk("pre_redir_addr", mem_addr, 32'h40);
    step(1'b1, 32'h203, 1'b1, 1'b0);
    chk("redir_ack_addr", mem_addr, 32'h200);
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 12) == 0, $urandom, ($urandom % 2) == 1, ($urandom % 4) != 0);
    end

    // Reset in the middle of a request with three entries buffered
    step(1'b1, 32'h500, 1'b1, 1'b0);
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0);
    redirect_valid = 1'b0;
    mem_ack        = 1'b0;
    inst_ready     = 1'b0;
    #1;
    chk("mid_pre_valid", {31'b0, inst_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req",   {31'b0, mem_req},    32'h0);
    chk("mid_rst_valid", {31'b0, inst_valid}, 32'h0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("post_rst_addr", mem_addr, 32'h0);
    repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
